// File: rtl/ioports_host_sched_pkg.sv
// Shared op codes, ioports command codes and scheduler states
// for the ioports host-side scheduler.
package ioports_host_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_RESET = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    localparam logic [2:0] CMD_RESET = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_READ  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WBYTE,
        S_RREQ,
        S_RHI,
        S_RLO,
        S_GAP,
        S_FIN
    } state_e;

    function automatic logic [7:0] cmd_byte(input op_e op, input logic [3:0] addr);
        logic [2:0] c;
        case (op)
            OP_RESET: c = CMD_RESET;
            OP_WRITE: c = CMD_WRITE;
            OP_READ:  c = CMD_READ;
            default:  c = 3'b000;
        endcase
        return {1'b0, c, addr};
    endfunction

endpackage

// File: rtl/ioports_host_sched_arb.sv
// Round-robin arbiter: first request at/after the pointer wins,
// pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    logic [PW-1:0] ptr_q;
    logic          hit;
    int            j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (!hit && req_i[j]) begin
                hit   = 1'b1;
                idx_o = PW'(j);
            end
        end
        if (en_i && hit) gnt_o[idx_o] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en_i && hit) begin
            ptr_q <= (idx_o == PW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/ioports_host_sched.sv
// Host scheduler serialising granted requests onto the ioports byte link.
// Define IOPORTS_SCHED_TIMEOUT_EN to enable the read-handshake timeout.
module ioports_host_sched
    import ioports_host_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int GAP     = 2,
    parameter int TMO_CYC = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [4*NREQ-1:0]  req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic             done,
    output logic [2:0]       done_id,
    output logic [31:0]      rdata,
    output logic             err,
    output logic             busy,
    output logic             io_load,
    output logic [7:0]       io_datain,
    output logic             io_ready,
    input  logic             io_enout,
    input  logic [7:0]       io_dataout
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(GAP) + 2;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [3:0]     addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [2:0]     id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    sh_q, sh_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [PW-1:0]  arb_idx;
    logic           arb_en;
    logic           tmo_hit;
    int             sel;

    assign arb_en = (state_q == S_IDLE) && !reset;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (arb_en),
        .req_i (req),
        .gnt_o (gnt),
        .idx_o (arb_idx)
    );

`ifdef IOPORTS_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;
    logic          in_wait;

    assign in_wait = (state_q == S_RHI) || (state_q == S_RLO);
    assign tmo_hit = in_wait && (tmo_q == TW'(TMO_CYC - 1));

    // The count spans one byte's handshake; RREQ rearms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= in_wait ? tmo_q + 1'b1 : '0;
            if (state_q == S_IDLE) begin
                err_q <= 1'b0;
            end else if (tmo_hit && ((state_q == S_RHI && !io_enout) ||
                                     (state_q == S_RLO && io_enout))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q && done;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rdata_d   = rdata_q;
        io_load   = 1'b0;
        io_datain = '0;
        io_ready  = 1'b0;
        done      = 1'b0;
        sel       = int'(arb_idx);
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    op_d    = op_e'(req_op[2*sel +: 2]);
                    addr_d  = req_addr[4*sel +: 4];
                    wdata_d = req_wdata[32*sel +: 32];
                    id_d    = 3'(arb_idx);
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = (op_d == OP_NOP) ? S_FIN : S_CMD;
                end
            end
            S_CMD: begin
                io_load   = 1'b1;
                io_datain = cmd_byte(op_q, addr_q);
                cnt_d     = '0;
                case (op_q)
                    OP_WRITE: state_d = S_WBYTE;
                    OP_READ:  state_d = S_RREQ;
                    default:  state_d = S_GAP;
                endcase
            end
            S_WBYTE: begin
                io_load   = 1'b1;
                io_datain = wdata_q[8*(3-int'(cnt_q)) +: 8];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(3)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_RREQ: begin
                io_ready = 1'b1;
                state_d  = S_RHI;
            end
            S_RHI: begin
                io_ready = 1'b1;
                if (io_enout) begin
                    sh_d[8*(3-int'(cnt_q)) +: 8] = io_dataout;
                    io_ready = 1'b0;
                    state_d  = S_RLO;
                end else if (tmo_hit) begin
                    io_ready = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end
            end
            S_RLO: begin
                if (!io_enout) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_RREQ;
                    if (cnt_q == CW'(3)) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (tmo_hit) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                    if (op_q == OP_READ) rdata_d = sh_q;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
        end
    end

    assign done_id = done ? id_q : 3'd0;
    assign rdata   = rdata_q;
    assign busy    = (state_q != S_IDLE) || (|gnt);

endmodule

// File: tb/tb_ioports_host_sched.sv
// Directed bench for ioports_host_sched with byte/grant/done scoreboards
// and a simple ioports read responder.
module tb_ioports_host_sched;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
`ifdef IOPORTS_SCHED_TIMEOUT_EN
    localparam int TMO  = 15;
`else
    localparam int TMO  = 1023;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] req_op = '0;
    logic [4*NREQ-1:0] req_addr = '0;
    logic [32*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [2:0]        done_id;
    logic [31:0]       rdata;
    logic              err;
    logic              busy;
    logic              io_load;
    logic [7:0]        io_datain;
    logic              io_ready;
    logic              io_enout = 1'b0;
    logic [7:0]        io_dataout = '0;

    ioports_host_sched #(.NREQ(NREQ), .GAP(GAP), .TMO_CYC(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .done_id    (done_id),
        .rdata      (rdata),
        .err        (err),
        .busy       (busy),
        .io_load    (io_load),
        .io_datain  (io_datain),
        .io_ready   (io_ready),
        .io_enout   (io_enout),
        .io_dataout (io_dataout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         first;
    } byte_t;

    typedef struct {
        int          id;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          tail;
    } done_t;

    byte_t exp_b[$];
    done_t exp_d[$];
    int    exp_g[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          last_load = -100;
    int          outstanding = 0;
    int          n_gnt = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] model_word = '0;
    bit          model_en = 1'b0;
    logic [1:0]  mbyte = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ioports read responder: one byte per io_ready pulse, MS byte first
    always @(posedge clk) begin
        if (reset) begin
            io_enout <= 1'b0;
            mbyte    <= '0;
        end else if (io_enout) begin
            if (!io_ready) io_enout <= 1'b0;
        end else if (io_ready && model_en) begin
            io_enout   <= 1'b1;
            io_dataout <= model_word[8*(3-int'(mbyte)) +: 8];
            mbyte      <= mbyte + 1'b1;
        end
    end

    always @(negedge clk) begin
        int    gi;
        byte_t e;
        done_t d;
        if (reset) begin
            outstanding = 0;
            last_load   = -100;
        end else begin
            if (|gnt) begin
                gi = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
                check("gnt_onehot", $countones(gnt), 1);
                check("gnt_not_busy", outstanding, 0);
                check("gnt_expected", exp_g.size() > 0, 1);
                if (exp_g.size() > 0) check("gnt_id", gi, exp_g.pop_front());
                gnt_cyc = cyc;
                outstanding++;
                n_gnt++;
            end
            if (io_load) begin
                check("load_vs_ready", io_ready, 0);
                check("byte_expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check("byte", io_datain, e.b);
                    if (e.first) check("cmd_gap", (cyc - last_load) > GAP, 1);
                end
                last_load = cyc;
            end
            if (done) begin
                check("done_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) begin
                    d = exp_d.pop_front();
                    check("done_id", done_id, d.id);
                    check("rdata", rdata, d.rd);
                    check("err", err, d.er);
                    check("ready_at_done", io_ready, 0);
                    check("busy_at_done", busy, 1);
                    if (d.lat >= 0) check("latency", cyc - gnt_cyc, d.lat);
                    if (d.tail >= 0) check("tail", cyc - last_load, d.tail);
                end
                outstanding--;
            end
        end
    end

    task automatic issue(input int id, input logic [1:0] op, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [31:0] rw, input bit want_done);
        int    k;
        done_t d;
        req_op[2*id +: 2]    = op;
        req_addr[4*id +: 4]  = addr;
        req_wdata[32*id +: 32] = wd;
        exp_g.push_back(id);
        if (op != 2'b00) exp_b.push_back('{b: {2'b00, op, addr}, first: 1'b1});
        if (op == 2'b10)
            for (int i = 3; i >= 0; i--) exp_b.push_back('{b: wd[8*i +: 8], first: 1'b0});
        if (op == 2'b11) begin
            model_word = rw;
            last_rd    = rw;
        end
        d.id   = id;
        d.rd   = last_rd;
        d.er   = 1'b0;
        d.lat  = (op == 2'b00) ? 1 : (op == 2'b01) ? 2 + GAP : (op == 2'b10) ? 6 + GAP : -1;
        d.tail = (op == 2'b01 || op == 2'b10) ? GAP + 1 : -1;
        if (want_done) exp_d.push_back(d);
        req[id] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[id] && k < 300);
        check("granted", gnt[id], 1'b1);
        @(posedge clk);
        #1;
        req[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_d.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("drained", exp_d.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int k;
        done_t d;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_busy", busy, 0);
        check("rst_load", io_load, 0);
        check("rst_datain", io_datain, 0);
        check("rst_ready", io_ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;

        // single write, then single read
        issue(0, 2'b10, 4'd3, 32'hDEADBEEF, '0, 1'b1);
        wait_idle();
        model_en = 1'b1;
        issue(1, 2'b11, 4'd5, '0, 32'h12345678, 1'b1);
        wait_idle();

        // back-to-back writes, second behind the address-15 one
        issue(2, 2'b10, 4'd15, 32'h0BAD_F00D, '0, 1'b1);
        issue(3, 2'b10, 4'd0, 32'hCAFE_1234, '0, 1'b1);
        wait_idle();

        // all four held: rotation 0,1,2,3,0 with pointer back at 0
        base = n_gnt;
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2]   = 2'b01;
            req_addr[4*i +: 4] = 4'(i);
        end
        for (int n = 0; n < 5; n++) begin
            exp_g.push_back(n % NREQ);
            exp_b.push_back('{b: 8'h10 | 8'(n % NREQ), first: 1'b1});
            d = '{id: n % NREQ, rd: last_rd, er: 1'b0, lat: 2 + GAP, tail: GAP + 1};
            exp_d.push_back(d);
        end
        req = '1;
        k = 0;
        while (n_gnt < base + 5 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        req = '0;
        check("rr_grants", n_gnt - base, 5);
        wait_idle();

        // no-op request: done next cycle, no bus traffic
        issue(0, 2'b00, 4'd9, '0, '0, 1'b1);
        wait_idle();

        // reset while stalled in the read handshake
        model_en = 1'b0;
        issue(1, 2'b11, 4'd7, '0, '0, 1'b0);
        k = 0;
        while (!io_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_ready", io_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", io_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_rdata", rdata, 0);
        last_rd  = '0;
        model_en = 1'b1;
        @(posedge clk);
        #1;
        issue(2, 2'b11, 4'd9, '0, 32'hA5C3_0F96, 1'b1);
        wait_idle();

`ifdef IOPORTS_SCHED_TIMEOUT_EN
        model_en = 1'b0;
        d = '{id: 3, rd: 32'h0, er: 1'b1, lat: -1, tail: -1};
        exp_d.push_back(d);
        issue(3, 2'b11, 4'd2, '0, '0, 1'b0);
        last_rd = '0;
        wait_idle();
        check("tmo_ready_low", io_ready, 0);
`endif

        check("bytes_left", exp_b.size(), 0);
        check("grants_left", exp_g.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
